// File: rtl/avg_seq_pkg.sv
// Shared types, defaults and width helper for the serial averaging controller.
package avg_seq_pkg;

  typedef enum logic [1:0] {ACC, SHIFT, OUT} state_t;

  localparam int DEF_DATAWIDTH   = 16;
  localparam int DEF_ACCWIDTH    = 32;
  localparam int DEF_NUM_SAMPLES = 8;
  localparam int DEF_SHIFT_STEPS = 3;

  // Ceiling log2, never below 1 so it can size a register directly.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/avg_seq_dp.sv
// Averaging datapath: accumulator, one shared adder, one shared logical
// right shifter and the registered average, all driven by control strobes.
module avg_seq_dp #(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_add,
  input  logic                 do_shift,
  input  logic                 clear,
  input  logic                 load_avg,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic [7:0]           sa_q,
  output logic [DATAWIDTH-1:0] avg
);

  logic [ACCWIDTH-1:0] acc;
  logic [ACCWIDTH-1:0] sum;
  logic [ACCWIDTH-1:0] shifted;

  assign sum = acc + ACCWIDTH'(in_data);
  // Oversized shift amounts flush to zero rather than wrapping.
  assign shifted = (int'(sa_q) >= ACCWIDTH) ? '0 : (acc >> sa_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      avg <= '0;
    end else begin
      if (clear)         acc <= '0;
      else if (do_shift) acc <= shifted;
      else if (load_add) acc <= sum;
      // load_avg alongside load_add only happens when no shifts are configured.
      if (load_avg) avg <= do_shift ? shifted[DATAWIDTH-1:0] : sum[DATAWIDTH-1:0];
    end
  end

endmodule

// File: rtl/avg_seq_ctrl.sv
// Sequencing controller: accepts NUM_SAMPLES samples, runs SHIFT_STEPS shifts
// on the shared datapath, then holds the average until the consumer takes it.
module avg_seq_ctrl
  import avg_seq_pkg::*;
#(
  parameter int DATAWIDTH   = DEF_DATAWIDTH,
  parameter int ACCWIDTH    = DEF_ACCWIDTH,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int SHIFT_STEPS = DEF_SHIFT_STEPS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATAWIDTH-1:0]                 in_data,
  input  logic [7:0]                           sa,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATAWIDTH-1:0]                 avg,
  output logic                                 busy,
  output logic [clog2(NUM_SAMPLES+1)-1:0]      count
);

  localparam int CW  = clog2(NUM_SAMPLES + 1);
  localparam int SCW = clog2(SHIFT_STEPS + 1);

  state_t         state, nstate;
  logic [7:0]     sa_q;
  logic [SCW-1:0] shift_cnt;
  logic           load_add, do_shift, clear, load_avg;
  logic           last_sample, last_shift;

  assign last_sample = (count == CW'(NUM_SAMPLES - 1));
  assign last_shift  = (shift_cnt == SCW'(SHIFT_STEPS - 1));

  assign in_ready = (state == ACC);
  assign busy     = (count != '0) || (state != ACC);

  always_comb begin
    nstate   = state;
    load_add = 1'b0;
    do_shift = 1'b0;
    clear    = 1'b0;
    load_avg = 1'b0;
    case (state)
      ACC: if (in_valid) begin
        load_add = 1'b1;
        if (last_sample) begin
          if (SHIFT_STEPS == 0) begin
            load_avg = 1'b1;
            nstate   = OUT;
          end else begin
            nstate = SHIFT;
          end
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (last_shift) begin
          load_avg = 1'b1;
          nstate   = OUT;
        end
      end
      // out_valid is always set while in OUT, so out_ready alone completes it.
      OUT: if (out_ready) begin
        clear  = 1'b1;
        nstate = ACC;
      end
      default: nstate = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      count     <= '0;
      sa_q      <= '0;
      shift_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= nstate;
      if (load_add)   count <= count + 1'b1;
      else if (clear) count <= '0;
      if (load_add && count == '0) sa_q <= sa;
      if (state == SHIFT) shift_cnt <= shift_cnt + 1'b1;
      else                shift_cnt <= '0;
      if (load_avg)   out_valid <= 1'b1;
      else if (clear) out_valid <= 1'b0;
    end
  end

  avg_seq_dp #(
    .DATAWIDTH (DATAWIDTH),
    .ACCWIDTH  (ACCWIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_add (load_add),
    .do_shift (do_shift),
    .clear    (clear),
    .load_avg (load_avg),
    .in_data  (in_data),
    .sa_q     (sa_q),
    .avg      (avg)
  );

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Scoreboard bench for avg_seq_ctrl with default parameters.
module tb_avg_seq_ctrl;

  localparam int NS = 8;
  localparam int SS = 3;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [7:0]  sa;
  logic        out_valid, out_ready;
  logic [15:0] avg;
  logic        busy;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  avg_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sa(sa), .out_valid(out_valid), .out_ready(out_ready),
    .avg(avg), .busy(busy), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] d[8], input logic [7:0] s);
    logic [31:0] a;
    a = 32'd0;
    for (int i = 0; i < NS; i++) a = a + {16'd0, d[i]};
    for (int k = 0; k < SS; k++) a = (s >= 8'd32) ? 32'd0 : (a >> s);
    return a[15:0];
  endfunction

  // Output monitor: compare each output handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: avg=%h with empty scoreboard", avg);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (avg !== e) begin
          errors++;
          $display("FAIL out_avg: got %h expected %h", avg, e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [7:0] s);
    int n;
    n = 0;
    in_valid = 1; in_data = d; sa = s;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_batch(input logic [15:0] d[8], input logic [7:0] sa0,
                           input logic [7:0] sa_rest, input int gap);
    exp_q.push_back(model(d, sa0));
    for (int i = 0; i < NS; i++) begin
      send(d[i], (i == 0) ? sa0 : sa_rest);
      checks++;
      if (count !== 4'(i + 1)) begin
        errors++;
        $display("FAIL batch_count: got %0d expected %0d", count, i + 1);
      end
      if (i != NS - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_data = 0; sa = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks += 5;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (count !== 4'd0)     begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    if (avg !== 16'd0)      begin errors++; $display("FAIL rst_avg: got %h expected 0", avg); end
  endtask

  task automatic test_basic_latency();
    logic [15:0] b[8];
    b = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_batch(b, 8'd1, 8'd1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (k == 3)) begin
        errors++;
        $display("FAIL latency_out_valid: cycle %0d got %b expected %b", k, out_valid, (k == 3));
      end
    end
    wait_idle();
  endtask

  task automatic test_saturating_truncate();
    logic [15:0] b[8];
    b = '{default: 16'hFFFF};
    run_batch(b, 8'd1, 8'd1, 0);
    wait_idle();
    b = '{default: 16'h4000};
    run_batch(b, 8'd0, 8'd0, 0);
    wait_idle();
  endtask

  task automatic test_sa_latch();
    logic [15:0] b[8];
    b = '{default: 16'h1234};
    run_batch(b, 8'd40, 8'd1, 0);
    wait_idle();
  endtask

  task automatic test_out_stall();
    logic [15:0] b[8];
    int n;
    b = '{1, 2, 3, 4, 5, 6, 7, 8};
    out_ready = 0;
    run_batch(b, 8'd1, 8'd1, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      checks += 4;
      if (avg !== 16'h0004)   begin errors++; $display("FAIL stall_avg: got %h expected 0004", avg); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      if (count !== 4'd8)     begin errors++; $display("FAIL stall_count: got %0d expected 8", count); end
      in_valid = 1; in_data = 16'h7777;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    if (count !== 4'd0)     begin errors++; $display("FAIL release_count: got %0d expected 0", count); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    if (avg !== 16'h0004)   begin errors++; $display("FAIL release_avg_hold: got %h expected 0004", avg); end
  endtask

  task automatic test_gaps();
    logic [15:0] b[8];
    b = '{10, 20, 30, 40, 50, 60, 70, 80};
    run_batch(b, 8'd1, 8'd1, 2);
    wait_idle();
  endtask

  task automatic test_async_reset();
    logic [15:0] b[8];
    for (int i = 0; i < 5; i++) send(16'(i + 1), 8'd1);
    checks++;
    if (count !== 4'd5) begin errors++; $display("FAIL pre_rst_count: got %0d expected 5", count); end
    #3 rst = 1;
    #1;
    checks += 4;
    if (count !== 4'd0)         begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
    if (out_valid !== 1'b0)     begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    if (dut.u_dp.acc !== 32'd0) begin errors++; $display("FAIL arst_acc: got %h expected 0", dut.u_dp.acc); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    #2 rst = 0;
    @(posedge clk); #1;
    b = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_batch(b, 8'd1, 8'd1, 0);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_saturating_truncate();
    test_sa_latch();
    test_out_stall();
    test_gaps();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outputs missing, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
